// File: rtl/mixer_sequencer_if.sv
// Output sample handshake between the mixer sequencer and the codec/I2S stage.
interface mixer_sequencer_if #(
    parameter int unsigned OUT_W = 24
);
    logic signed [OUT_W-1:0] sample;
    logic                    sample_valid;
    logic                    sample_ack;

    modport master (output sample, output sample_valid, input sample_ack);
    modport slave  (input sample, input sample_valid, output sample_ack);
endinterface

// File: rtl/mixer_sequencer.sv
// Frame scheduler for the voice mixer: reads each voice, feeds the mixer, holds the result.
// Optional feature macro MIXSEQ_VOICE_SKIP_EN: no bank read for voices whose active bit is 0.
module mixer_sequencer #(
    parameter int unsigned NUM_VOICES  = 10,
    parameter int unsigned IN_W        = 23,
    parameter int unsigned OUT_W       = 24,
    parameter int unsigned RDY_TIMEOUT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_sample_req,
    input  logic [NUM_VOICES-1:0]   i_voice_active,
    output logic [3:0]              o_voice_sel,
    output logic                    o_voice_rd,
    input  logic signed [IN_W-1:0]  i_voice_data,
    output logic                    o_mix_en,
    output logic signed [IN_W-1:0]  o_mix_data,
    input  logic                    i_mix_rdy,
    input  logic signed [OUT_W-1:0] i_mix_data,
    mixer_sequencer_if.master       o_sample_if,
    output logic                    o_busy,
    output logic                    o_overrun,
    output logic                    o_drop,
    output logic                    o_err
);
    localparam logic [3:0] LastVoice = 4'(NUM_VOICES - 1);
    localparam logic [3:0] LastWait  = 4'(RDY_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StFeed, StWaitRdy} state_e;

    state_e                  r_state;
    state_e                  w_state_d;
    logic [3:0]              r_cnt;
    logic [3:0]              w_cnt_d;
    logic                    r_mix_en;
    logic                    r_gate;
    logic                    r_overrun;
    logic                    r_drop;
    logic                    r_err;
    logic                    r_valid;
    logic signed [OUT_W-1:0] r_sample;
    logic                    w_capture;
    logic                    w_timeout;
    logic                    w_active;

    // r_cnt is the voice index in StFetch and the ready-wait counter in StWaitRdy.
    assign w_active = i_voice_active[r_cnt];

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_capture = 1'b0;
        w_timeout = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_cnt_d = '0;
                if (i_sample_req) begin
                    w_state_d = StFetch;
                end
            end
            StFetch: begin
                if (r_cnt == LastVoice) begin
                    w_cnt_d   = '0;
                    w_state_d = StFeed;
                end else begin
                    w_cnt_d = r_cnt + 4'd1;
                end
            end
            StFeed: begin
                w_cnt_d   = '0;
                w_state_d = StWaitRdy;
            end
            StWaitRdy: begin
                if (i_mix_rdy) begin
                    w_capture = 1'b1;
                    w_cnt_d   = '0;
                    w_state_d = StIdle;
                end else if (r_cnt == LastWait) begin
                    w_timeout = 1'b1;
                    w_cnt_d   = '0;
                    w_state_d = StIdle;
                end else begin
                    w_cnt_d = r_cnt + 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_mix_en  <= 1'b0;
            r_gate    <= 1'b0;
            r_overrun <= 1'b0;
            r_drop    <= 1'b0;
            r_err     <= 1'b0;
            r_valid   <= 1'b0;
            r_sample  <= '0;
        end else begin
            r_state   <= w_state_d;
            r_cnt     <= w_cnt_d;
            // Mixer enable trails each read by one cycle, matching bank read latency.
            r_mix_en  <= (r_state == StFetch);
            r_gate    <= (r_state == StFetch) && w_active;
            r_overrun <= i_sample_req && (r_state != StIdle);
            r_drop    <= w_capture && r_valid && !o_sample_if.sample_ack;
            if (w_capture) begin
                r_sample <= i_mix_data;
                r_valid  <= 1'b1;
            end else if (r_valid && o_sample_if.sample_ack) begin
                r_valid <= 1'b0;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_busy      = (r_state != StIdle);
    assign o_voice_sel = (r_state == StFetch) ? r_cnt : 4'd0;
`ifdef MIXSEQ_VOICE_SKIP_EN
    assign o_voice_rd  = (r_state == StFetch) && w_active;
`else
    assign o_voice_rd  = (r_state == StFetch);
`endif
    assign o_mix_en    = r_mix_en;
    assign o_mix_data  = r_gate ? i_voice_data : '0;
    assign o_overrun   = r_overrun;
    assign o_drop      = r_drop;
    assign o_err       = r_err;

    assign o_sample_if.sample       = r_sample;
    assign o_sample_if.sample_valid = r_valid;
endmodule

// File: tb/tb_mixer_sequencer.sv
// Self-checking bench for mixer_sequencer: voice bank and mixer stand-ins plus a frame-level model.
module tb_mixer_sequencer;
    localparam int NV      = 10;
    localparam int TIMEOUT = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                req = 1'b0;
    logic [NV-1:0]       active = '0;
    logic [3:0]          voice_sel;
    logic                voice_rd;
    logic signed [22:0]  voice_data = '0;
    logic                mix_en;
    logic signed [22:0]  mix_data_o;
    logic                mix_rdy = 1'b0;
    logic signed [23:0]  mix_data_i = '0;
    logic                busy;
    logic                overrun;
    logic                drop;
    logic                err;
    logic                no_rdy = 1'b0;

    mixer_sequencer_if #(.OUT_W(24)) smp_if ();

    mixer_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .i_sample_req   (req),
        .i_voice_active (active),
        .o_voice_sel    (voice_sel),
        .o_voice_rd     (voice_rd),
        .i_voice_data   (voice_data),
        .o_mix_en       (mix_en),
        .o_mix_data     (mix_data_o),
        .i_mix_rdy      (mix_rdy),
        .i_mix_data     (mix_data_i),
        .o_sample_if    (smp_if),
        .o_busy         (busy),
        .o_overrun      (overrun),
        .o_drop         (drop),
        .o_err          (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Voice bank contents and bank/mixer stand-ins.
    logic signed [22:0] vbank [NV];
    logic               rd_s, en_s;
    logic [3:0]         sel_s;
    logic signed [22:0] md_s;
    logic signed [23:0] acc = '0;
    int                 nacc = 0;
    int                 en_cnt = 0;
    int                 drop_cnt = 0;

    always @(negedge clk) begin
        rd_s  = voice_rd;
        sel_s = voice_sel;
        en_s  = mix_en;
        md_s  = mix_data_o;
        if (mix_en) en_cnt++;
        if (drop) drop_cnt++;
    end

    always @(posedge clk) begin
        #1;
        if (rst) begin
            acc        = '0;
            nacc       = 0;
            mix_rdy    = 1'b0;
            mix_data_i = '0;
        end else begin
            voice_data = rd_s ? vbank[sel_s] : 23'sh2ABCDE;
            mix_rdy    = 1'b0;
            if (en_s) begin
                acc = acc + md_s;
                nacc++;
                if (nacc == NV) begin
                    mix_rdy    = !no_rdy;
                    mix_data_i = acc;
                    acc        = '0;
                    nacc       = 0;
                end
            end
        end
    end

    // Frame-level model: a frame accepted at cycle f_t is described purely by cycle offsets.
    int                 cyc = 0;
    bit                 f_on = 1'b0;
    int                 f_t = 0;
    int                 f_end = 0;
    bit                 f_rdy = 1'b1;
    logic [NV-1:0]      f_mask = '0;
    logic signed [23:0] f_sum = '0;
    logic signed [23:0] m_sample = '0;
    bit                 m_valid = 1'b0;
    bit                 m_err = 1'b0;
    int                 m_ovr_at = -1;
    int                 m_drop_at = -1;

    task automatic model_clear();
        f_on      = 1'b0;
        m_sample  = '0;
        m_valid   = 1'b0;
        m_err     = 1'b0;
        m_ovr_at  = -1;
        m_drop_at = -1;
    endtask

    always @(posedge rst) model_clear();

    always @(posedge clk) begin
        int c;
        c = cyc;
        if (rst) begin
            model_clear();
        end else begin
            if (f_on && f_rdy && c == f_t + 12) begin
                if (m_valid && !smp_if.sample_ack) m_drop_at = c + 1;
                m_sample = f_sum;
                m_valid  = 1'b1;
            end else if (m_valid && smp_if.sample_ack) begin
                m_valid = 1'b0;
            end
            if (f_on && !f_rdy && c == f_end) m_err = 1'b1;
            if (req) begin
                if (f_on && c >= f_t + 1 && c <= f_end) begin
                    m_ovr_at = c + 1;
                end else begin
                    f_on   = 1'b1;
                    f_t    = c;
                    f_rdy  = !no_rdy;
                    f_end  = f_rdy ? c + 12 : c + 11 + TIMEOUT;
                    f_mask = active;
                    f_sum  = '0;
                    for (int k = 0; k < NV; k++) begin
                        if (active[k]) f_sum = f_sum + vbank[k];
                    end
                end
            end
        end
        cyc = c + 1;
    end

    always @(negedge clk) begin
        int                 off;
        logic               e_rd;
        logic               e_en;
        logic               e_busy;
        logic [3:0]         e_sel;
        logic signed [22:0] e_md;
        off    = cyc - f_t;
        e_rd   = f_on && off >= 1 && off <= NV;
        e_sel  = e_rd ? 4'(off - 1) : 4'd0;
`ifdef MIXSEQ_VOICE_SKIP_EN
        if (e_rd && !f_mask[off-1]) e_rd = 1'b0;
`endif
        e_en   = f_on && off >= 2 && off <= NV + 1;
        e_md   = '0;
        if (e_en && f_mask[off-2]) e_md = vbank[off-2];
        e_busy = f_on && off >= 1 && cyc <= f_end;
        chk("rd", voice_rd, e_rd);
        chk("sel", voice_sel, e_sel);
        chk("mix_en", mix_en, e_en);
        chk("mix_data", mix_data_o, e_md);
        chk("busy", busy, e_busy);
        chk("valid", smp_if.sample_valid, m_valid);
        chk("sample", smp_if.sample, m_sample);
        chk("overrun", overrun, cyc == m_ovr_at);
        chk("drop", drop, cyc == m_drop_at);
        chk("err", err, m_err);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic bank_lin();
        for (int k = 0; k < NV; k++) vbank[k] = 23'(1000 * (k + 1));
    endtask

    task automatic start_frame(output int t);
        t   = cyc;
        req = 1'b1;
        step();
        req = 1'b0;
    endtask

    task automatic ack_once();
        smp_if.sample_ack = 1'b1;
        step();
        smp_if.sample_ack = 1'b0;
    endtask

    initial begin
        int t;
        int t2;
        smp_if.sample_ack = 1'b0;
        for (int k = 0; k < NV; k++) vbank[k] = '0;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_rd", voice_rd, 0);
        chk("rst_mix_en", mix_en, 0);
        chk("rst_valid", smp_if.sample_valid, 0);
        chk("rst_sample", smp_if.sample, 0);
        chk("rst_err", err, 0);
        #1 rst = 1'b0;
        step();

        // Full frame, all voices active.
        bank_lin();
        active = '1;
        start_frame(t);
        chk("a_rd_t1", voice_rd, 1);
        go_to(t + 11);
        chk("a_en_t11", mix_en, 1);
        go_to(t + 12);
        chk("a_en_t12", mix_en, 0);
        chk("a_valid_t12", smp_if.sample_valid, 0);
        go_to(t + 13);
        chk("a_sample", smp_if.sample, 55000);
        chk("a_valid_t13", smp_if.sample_valid, 1);
        go_to(t + 15);
        ack_once();
        chk("a_valid_t16", smp_if.sample_valid, 0);

        // Mask 0b101 with equal data.
        for (int k = 0; k < NV; k++) vbank[k] = 23'sh100000;
        active = 10'b0000000101;
        start_frame(t);
        step();
`ifdef MIXSEQ_VOICE_SKIP_EN
        chk("b_rd_sel1", voice_rd, 0);
`else
        chk("b_rd_sel1", voice_rd, 1);
`endif
        go_to(t + 13);
        chk("b_sample", smp_if.sample, 24'sh200000);
        ack_once();

        // Overrun request at T+5.
        bank_lin();
        active = '1;
        en_cnt = 0;
        start_frame(t);
        go_to(t + 5);
        req = 1'b1;
        step();
        req = 1'b0;
        chk("c_overrun", overrun, 1);
        go_to(t + 13);
        chk("c_sample", smp_if.sample, 55000);
        chk("c_en_count", en_cnt, 10);
        ack_once();

        // Two unacked frames; second request lands in the cycle IDLE is re-entered.
        drop_cnt = 0;
        start_frame(t);
        go_to(t + 13);
        chk("d_sample1", smp_if.sample, 55000);
        for (int k = 0; k < NV; k++) vbank[k] = '0;
        vbank[0] = 23'sd10;
        start_frame(t2);
        go_to(t2 + 13);
        chk("d_drop", drop, 1);
        chk("d_sample2", smp_if.sample, 10);
        step();
        chk("d_drop_cnt", drop_cnt, 1);
        chk("d_valid", smp_if.sample_valid, 1);

        // Ack in the capture cycle with a negative sum.
        for (int k = 0; k < NV; k++) vbank[k] = -23'sd5;
        start_frame(t);
        go_to(t + 12);
        ack_once();
        chk("e_sample", smp_if.sample, -50);
        chk("e_valid", smp_if.sample_valid, 1);
        chk("e_no_drop", drop, 0);
        ack_once();
        chk("e_valid_clr", smp_if.sample_valid, 0);

        // Asynchronous reset mid-frame, then a clean frame.
        bank_lin();
        start_frame(t);
        go_to(t + 6);
        rst = 1'b1;
        #1;
        chk("f_busy", busy, 0);
        chk("f_rd", voice_rd, 0);
        chk("f_mix_en", mix_en, 0);
        chk("f_sample", smp_if.sample, 0);
        step();
        #1 rst = 1'b0;
        step();
        start_frame(t);
        go_to(t + 13);
        chk("f_sample2", smp_if.sample, 55000);
        chk("f_valid2", smp_if.sample_valid, 1);
        ack_once();

        // Mixer never ready.
        no_rdy = 1'b1;
        start_frame(t);
        go_to(t + 15);
        chk("g_err_early", err, 0);
        chk("g_busy", busy, 1);
        go_to(t + 16);
        chk("g_err", err, 1);
        chk("g_idle", busy, 0);
        chk("g_sample_kept", smp_if.sample, 55000);
        no_rdy = 1'b0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1);
    end
endmodule
